ram_bist_ctrl: RTL and testbench

Synthesizable built-in self-test initiator for single_port_ram. It drives the RAM's we/addr/din port and checks dout. One start pulse runs a fixed sequence: clear all, write then read back each word, then a full-sweep verify. The result is reported as pass/fail, an error count and the first failing address. It sits between the system control logic and one single_port_ram instance.

---
 rtl/ram_bist_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// Built-in self-test initiator for a single-port RAM with registered read data.
// One start pulse runs clear, write/read-back per word, then a pipelined full-sweep verify.
module ram_bist_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ERR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WRITE,
        READ,
        CHECK,
        VERIFY,
        DRAIN,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = '1;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   index, index_nxt;
    logic [ERR_WIDTH-1:0]    err_nxt;
    logic [ADDR_WIDTH-1:0]   fail_nxt;
    logic                    pass_nxt;
    logic                    busy_nxt, done_nxt, we_nxt;
    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic [DATA_WIDTH-1:0]   din_nxt;
    logic                    cmp_en;
    logic [ADDR_WIDTH-1:0]   cmp_addr;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] i);
        logic [DATA_WIDTH-1:0] p;
        p = DATA_WIDTH'(i);
        return p + p + p + DATA_WIDTH'(5);
    endfunction

    always_comb begin
        state_nxt = state;
        index_nxt = index;
        err_nxt   = err_count;
        fail_nxt  = fail_addr;
        pass_nxt  = pass;
        cmp_en    = 1'b0;
        cmp_addr  = index;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CLEAR;
                    index_nxt = '0;
                    err_nxt   = '0;
                    fail_nxt  = '0;
                    pass_nxt  = 1'b0;
                end
            end
            CLEAR: begin
                index_nxt = index + 1'b1;
                if (index == LAST) begin
                    state_nxt = WRITE;
                    index_nxt = '0;
                end
            end
            WRITE: state_nxt = READ;
            READ:  state_nxt = CHECK;
            CHECK: begin
                cmp_en    = 1'b1;
                state_nxt = WRITE;
                index_nxt = index + 1'b1;
                if (index == LAST) begin
                    state_nxt = VERIFY;
                    index_nxt = '0;
                end
            end
            VERIFY: begin
                // Read data lags the issued address by one cycle; the first issue has nothing to compare.
                cmp_en    = (index != '0);
                cmp_addr  = index - 1'b1;
                index_nxt = index + 1'b1;
                if (index == LAST) begin
                    state_nxt = DRAIN;
                    index_nxt = index;
                end
            end
            DRAIN: begin
                cmp_en    = 1'b1;
                state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (cmp_en && (ram_dout != pattern(cmp_addr))) begin
            if (err_count != '1) begin
                err_nxt = err_count + 1'b1;
            end
            if (err_count == '0) begin
                fail_nxt = cmp_addr;
            end
        end

        if (state_nxt == DONE) begin
            pass_nxt = (err_nxt == '0);
        end
    end

    // Port outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
        we_nxt   = 1'b0;
        addr_nxt = ram_addr;
        din_nxt  = '0;
        case (state_nxt)
            CLEAR: begin
                we_nxt   = 1'b1;
                addr_nxt = index_nxt;
            end
            WRITE: begin
                we_nxt   = 1'b1;
                addr_nxt = index_nxt;
                din_nxt  = pattern(index_nxt);
            end
            READ, CHECK, VERIFY: addr_nxt = index_nxt;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            index     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
        end else begin
            state     <= state_nxt;
            index     <= index_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            pass      <= pass_nxt;
            err_count <= err_nxt;
            fail_addr <= fail_nxt;
            ram_we    <= we_nxt;
            ram_addr  <= addr_nxt;
            ram_din   <= din_nxt;
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: behavioural single-port RAM with fault/alias injection,
// expected run results queued at start and compared when the done pulse appears.
module tb_ram_bist_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int EW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, pass;
    logic [EW-1:0] err_count;
    logic [AW-1:0] fail_addr;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;

    ram_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_WIDTH(EW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_addr (fail_addr),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    always #5 clk = ~clk;

    // RAM model; alias_en drops address bit 3, fault_en flips dout bit0 for reads of address 4.
    logic [DW-1:0] mem [DEPTH];
    logic          alias_en = 1'b0;
    logic          fault_en = 1'b0;

    always @(posedge clk) begin : ram_model
        logic [AW-1:0] a;
        a = alias_en ? {1'b0, ram_addr[AW-2:0]} : ram_addr;
        if (ram_we) mem[a] <= ram_din;
        ram_dout <= mem[a] ^ ((fault_en && ram_addr == 4'd4) ? 8'h01 : 8'h00);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        return DW'(i * 3 + 5);
    endfunction

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned   start_cyc;
        logic [EW-1:0] err;
        logic [AW-1:0] fa;
        logic          pass;
    } exp_t;
    exp_t exp_q[$];

    logic din_bad = 1'b0;
    always @(negedge clk) if (!ram_we && ram_din != '0) din_bad = 1'b1;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("done_latency", cyc - e.start_cyc, 32'd81);
                check("err_count", 32'(err_count), 32'(e.err));
                check("fail_addr", 32'(fail_addr), 32'(e.fa));
                check("pass", 32'(pass), 32'(e.pass));
                check("busy_in_done", 32'(busy), 32'd1);
                check("din_zero_when_not_writing", 32'(din_bad), 32'd0);
            end
        end
    end

    task automatic run_bist(input logic [EW-1:0] e_err, input logic [AW-1:0] e_fa,
                            input logic e_pass, input int unsigned poke_at);
        exp_t e;
        int unsigned n;
        din_bad = 1'b0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        e.start_cyc = cyc;
        e.err  = e_err;
        e.fa   = e_fa;
        e.pass = e_pass;
        exp_q.push_back(e);
        check("busy_after_start", 32'(busy), 32'd1);
        check("err_cleared_on_start", 32'(err_count), 32'd0);
        check("fail_addr_cleared_on_start", 32'(fail_addr), 32'd0);
        check("pass_cleared_on_start", 32'(pass), 32'd0);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            start = (poke_at != 0 && n == poke_at);
        end
        start = 1'b0;
        if (exp_q.size() != 0) begin
            check("done_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end
        @(posedge clk);
        #1 check("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic check_mem();
        for (int i = 0; i < DEPTH; i++) check($sformatf("mem[%0d]", i), 32'(mem[i]), 32'(pat(i)));
    endtask

    initial begin
        logic we_seen;

        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_fail_addr", 32'(fail_addr), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_din", 32'(ram_din), 32'd0);
        rst_n = 1'b1;

        we_seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1 if (ram_we || busy) we_seen = 1'b1;
        end
        check("idle_without_start", 32'(we_seen), 32'd0);

        // Fault-free run
        run_bist(8'd0, 4'd0, 1'b1, 0);
        check_mem();

        // Read corruption at address 4: caught by CHECK and by VERIFY
        fault_en = 1'b1;
        run_bist(8'd2, 4'd4, 1'b0, 0);
        fault_en = 1'b0;

        // Address aliasing: upper half overwrites lower half
        alias_en = 1'b1;
        run_bist(8'd8, 4'd0, 1'b0, 0);
        alias_en = 1'b0;

        // Start during a run is ignored; then a clean repeat
        run_bist(8'd0, 4'd0, 1'b1, 30);
        run_bist(8'd0, 4'd0, 1'b1, 0);
        check_mem();

        // Reset mid-test (errors already counted) aborts with no done
        fault_en = 1'b1;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        check("busy_mid_run", 32'(busy), 32'd1);
        check("err_mid_run", 32'(err_count), 32'd1);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_we", 32'(ram_we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_err", 32'(err_count), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        fault_en = 1'b0;
        repeat (100) @(posedge clk);
        #1 check("abort_stays_idle", 32'(busy), 32'd0);

        run_bist(8'd0, 4'd0, 1'b1, 0);
        check_mem();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
